// File: rtl/zorro_dma_arbiter.sv
// Zorro II bus-master arbiter: registers slot requests and runs the BR/BG/BGACK handshake.
// Define ZORRO_ARB_ROUND_ROBIN_EN for rotating slot priority; otherwise slot 1 always wins.
module zorro_dma_arbiter #(
    parameter int unsigned GRANT_TIMEOUT = 15
) (
    input  logic       C7M,
    input  logic       RESET,
    input  logic [5:1] BR,
    input  logic       BGn,
    input  logic       BGACKn,
    input  logic       ASn,
    output logic       BRn,
    output logic [5:1] BG,
    output logic [2:0] OWNER,
    output logic       GRANT_TO
);

`ifdef ZORRO_ARB_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    localparam int unsigned        TIMER_W    = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GRANT_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ARB,
        S_GRANT,
        S_OWNED,
        S_RELEASE
    } state_t;

    state_t             state_q;
    logic [5:1]         sbr_q;
    logic               sbgn_q;
    logic               sbgackn_q;
    logic               sasn_q;
    logic               brn_q;
    logic [5:1]         bg_q;
    logic [2:0]         owner_q;
    logic               grant_to_q;
    logic [TIMER_W-1:0] timer_q;
    logic [2:0]         last_q;
    logic [2:0]         win_q;

    logic               win_found_d;
    logic [2:0]         win_d;
    logic [2:0]         cand;

    // Walk the five slots starting after the last owner, wrapping 5 -> 1.
    always_comb begin
        win_found_d = 1'b0;
        win_d       = 3'd0;
        cand        = last_q;
        for (int k = 0; k < 5; k++) begin
            cand = (cand == 3'd5) ? 3'd1 : cand + 3'd1;
            if (!win_found_d && !sbr_q[cand]) begin
                win_found_d = 1'b1;
                win_d       = cand;
            end
        end
    end

    always_ff @(posedge C7M) begin
        if (RESET) begin
            sbr_q      <= 5'b11111;
            sbgn_q     <= 1'b1;
            sbgackn_q  <= 1'b1;
            sasn_q     <= 1'b1;
            state_q    <= S_IDLE;
            brn_q      <= 1'b1;
            bg_q       <= 5'b11111;
            owner_q    <= 3'd0;
            grant_to_q <= 1'b0;
            timer_q    <= '0;
            last_q     <= 3'd5;
            win_q      <= 3'd0;
        end else begin
            sbr_q      <= BR;
            sbgn_q     <= BGn;
            sbgackn_q  <= BGACKn;
            sasn_q     <= ASn;
            grant_to_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    brn_q   <= 1'b1;
                    bg_q    <= 5'b11111;
                    owner_q <= 3'd0;
                    if (sbr_q != 5'b11111) begin
                        state_q <= S_REQ;
                        brn_q   <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (sbr_q == 5'b11111) begin
                        state_q <= S_RELEASE;
                        brn_q   <= 1'b1;
                    end else if (!sbgn_q) begin
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (!win_found_d) begin
                        state_q <= S_RELEASE;
                        brn_q   <= 1'b1;
                    end else if (sasn_q && sbgackn_q) begin
                        // Previous bus cycle has fully finished; safe to hand out BG.
                        state_q     <= S_GRANT;
                        bg_q        <= 5'b11111;
                        bg_q[win_d] <= 1'b0;
                        timer_q     <= '0;
                        win_q       <= win_d;
                    end
                end
                S_GRANT: begin
                    if (timer_q != TIMER_MAX) begin
                        timer_q <= timer_q + 1'b1;
                    end
                    if (!sbgackn_q) begin
                        state_q <= S_OWNED;
                        bg_q    <= 5'b11111;
                        brn_q   <= 1'b1;
                        owner_q <= win_q;
                        if (ROUND_ROBIN) begin
                            last_q <= win_q;
                        end
                    end else if (sbr_q[win_q]) begin
                        state_q <= S_RELEASE;
                        bg_q    <= 5'b11111;
                        brn_q   <= 1'b1;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q    <= S_RELEASE;
                        bg_q       <= 5'b11111;
                        brn_q      <= 1'b1;
                        grant_to_q <= 1'b1;
                        if (ROUND_ROBIN) begin
                            last_q <= win_q;
                        end
                    end
                end
                S_OWNED: begin
                    if (sbgackn_q) begin
                        state_q <= S_IDLE;
                        owner_q <= 3'd0;
                    end
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    brn_q   <= 1'b1;
                    bg_q    <= 5'b11111;
                    owner_q <= 3'd0;
                end
            endcase
        end
    end

    assign BRn      = brn_q;
    assign BG       = bg_q;
    assign OWNER    = owner_q;
    assign GRANT_TO = grant_to_q;

endmodule
